spi_tx_arbiter: RTL and testbench
=================================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of burst requesters (2..4).
REQ-002 The block SHALL have parameter IDX_W, default 16, giving the width of burst length and word index.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cs_n  input  1  SPI chip select from master (already synchronised into clk), low = frame active.
REQ-006 tx_ready  input  1  SPI slave has accepted tx_data (one-cycle pulse).
REQ-007 tx_data  output  32  word presented to SPI slave.
REQ-008 tx_valid  output  1  tx_data valid to SPI slave.
REQ-009 req  input  NUM_REQ  per-requester burst request, level.
REQ-010 len  input  NUM_REQ*IDX_W  per-requester burst length in words; slice i = requester i.
REQ-011 rd_data  input  NUM_REQ*32  per-requester word at rd_index, combinational from requester; slice i = requester i.
REQ-012 rd_index  output  IDX_W  word index being fetched from granted requester.
REQ-013 grant  output  NUM_REQ  one-hot owner of the SPI tx path; all-zero when idle.
REQ-014 done  output  NUM_REQ  one-cycle pulse on bit i when requester i's burst completes.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT_CS_LOW, PULSE_VALID, WAIT_READY, WAIT_CS_HIGH, DONE.
REQ-017 IDLE: when any req bit is high, the block SHALL select the winner round-robin, searching from (last_winner+1) mod NUM_REQ upward; after reset the search starts at requester 0.
REQ-018 On selection the block SHALL, on the next edge, set grant to the winner's one-hot, latch len of the winner into an internal count, clear rd_index to 0, and enter LOAD.
REQ-019 req and len SHALL be sampled only in IDLE; changes during a burst SHALL be ignored and the burst SHALL run to its latched length.
REQ-020 A latched length of 0 SHALL go IDLE -> DONE directly: grant high for exactly one cycle, done pulse, no tx_valid.
REQ-021 LOAD: tx_data SHALL be registered from the granted rd_data slice at current rd_index; next state WAIT_CS_LOW.
REQ-022 WAIT_CS_LOW: tx_valid SHALL be 0; on cs_n == 0 go to PULSE_VALID.
REQ-023 PULSE_VALID: tx_valid SHALL be set to 1; next state WAIT_READY.
REQ-024 WAIT_READY: tx_valid SHALL stay 1 until tx_ready; on tx_ready, tx_valid SHALL clear on the same edge and state goes WAIT_CS_HIGH.
REQ-025 WAIT_READY with cs_n == 1 and tx_ready == 0 (frame aborted) SHALL clear tx_valid, keep tx_data and rd_index, and return to WAIT_CS_LOW (same word retransmitted).
REQ-026 tx_ready and cs_n rising in the same cycle in WAIT_READY SHALL count as accepted (tx_ready has priority).
REQ-027 WAIT_CS_HIGH: on cs_n == 1, rd_index SHALL increment; if rd_index+1 equals the latched length go to DONE, else go to LOAD.
REQ-028 rd_index arithmetic SHALL be IDX_W bits unsigned; a length of 2^IDX_W-1 SHALL complete without wrap.
REQ-029 DONE: done bit of the owner SHALL pulse for exactly one cycle, grant SHALL clear on the following edge, last_winner SHALL update to the owner, next state IDLE.
REQ-030 A requester still holding req in IDLE after its done SHALL lose to any other pending requester (round-robin fairness).
REQ-031 tx_valid SHALL never be high while grant is all-zero or while cs_n was high at the previous edge outside WAIT_READY.

Reset
REQ-032 While rst is high at a clock edge: state = IDLE, tx_data = 0, tx_valid = 0, rd_index = 0, grant = 0, done = 0, busy = 0, last_winner = NUM_REQ-1.
REQ-033 rst asserted mid-burst SHALL abandon the burst with no done pulse; after release the block SHALL re-arbitrate from requester 0.

Verification
REQ-034 Single burst: req[0]=1, len0=3, words 0xA0,0xA1,0xA2, master runs 3 CS frames -> tx_data sequence 0xA0,0xA1,0xA2, one tx_valid per frame, done[0] one pulse after third cs_n rise.
REQ-035 Contention: req=2'b11 from reset, len0=len1=2 -> requester 0 served first, then 1; both held high again -> next order 0 then 1 alternating.
REQ-036 Abort: cs_n rises during WAIT_READY with no tx_ready -> tx_valid drops, same word re-sent in next frame, rd_index unchanged.
REQ-037 Zero length: req[1]=1, len1=0 -> grant=2'b10 one cycle, done[1] pulse, tx_valid never high.
REQ-038 Reset mid-burst: rst high after word 1 of 3 -> all outputs zero, no done, subsequent req[1] with req[0] both high grants requester 0.

Source files
------------

// File: rtl/spi_tx_arbiter_if.sv
// rtl/spi_tx_arbiter_if.sv - burst requester / SPI tx bundle between arbiter and its environment
interface spi_tx_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 16
) ();
   logic                       cs_n;
   logic                       tx_ready;
   logic [31:0]                tx_data;
   logic                       tx_valid;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*IDX_W-1:0]   len;
   logic [NUM_REQ*32-1:0]      rd_data;
   logic [IDX_W-1:0]           rd_index;
   logic [NUM_REQ-1:0]         grant;
   logic [NUM_REQ-1:0]         done;
   logic                       busy;

   modport slave (
      input  cs_n, tx_ready, req, len, rd_data,
      output tx_data, tx_valid, rd_index, grant, done, busy
   );

   modport master (
      output cs_n, tx_ready, req, len, rd_data,
      input  tx_data, tx_valid, rd_index, grant, done, busy
   );
endinterface

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin arbiter streaming requester bursts word-per-frame to an SPI slave
module spi_tx_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 16
) (
   input  logic          clk,
   input  logic          rst,
   spi_tx_arbiter_if.slave bus
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_CS_LOW,
      PULSE_VALID,
      WAIT_READY,
      WAIT_CS_HIGH,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic [IDX_W-1:0]   rd_index_q, rd_index_d;
   logic [IDX_W-1:0]   count_q, count_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      last_q, last_d;

   logic [OW-1:0]      win_idx;
   logic               win_found;
   logic [IDX_W-1:0]   win_len;
   logic [IDX_W-1:0]   idx_inc;
   logic [31:0]        owner_word;

   // Search starts one past the previous winner so a requester that keeps
   // req high cannot starve the others.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
            win_found = 1'b1;
            win_idx   = OW'((int'(last_q) + k) % NUM_REQ);
         end
      end
   end

   assign win_len    = bus.len[int'(win_idx)*IDX_W +: IDX_W];
   assign owner_word = bus.rd_data[int'(owner_q)*32 +: 32];
   assign idx_inc    = rd_index_q + IDX_W'(1);

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      rd_index_d = rd_index_q;
      count_d    = count_q;
      grant_d    = grant_q;
      done_d     = '0;
      owner_d    = owner_q;
      last_d     = last_q;

      case (state_q)
         IDLE: begin
            tx_valid_d = 1'b0;
            if (win_found) begin
               grant_d    = NUM_REQ'(1) << win_idx;
               owner_d    = win_idx;
               count_d    = win_len;
               rd_index_d = '0;
               if (win_len == '0) begin
                  state_d = DONE;
                  done_d  = NUM_REQ'(1) << win_idx;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            tx_data_d = owner_word;
            state_d   = WAIT_CS_LOW;
         end
         WAIT_CS_LOW: begin
            tx_valid_d = 1'b0;
            if (!bus.cs_n) begin
               state_d = PULSE_VALID;
            end
         end
         PULSE_VALID: begin
            tx_valid_d = 1'b1;
            state_d    = WAIT_READY;
         end
         WAIT_READY: begin
            // Acceptance wins over a simultaneous cs_n rise; a bare rise
            // aborts the frame and the same word is offered again.
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = WAIT_CS_HIGH;
            end else if (bus.cs_n) begin
               tx_valid_d = 1'b0;
               state_d    = WAIT_CS_LOW;
            end
         end
         WAIT_CS_HIGH: begin
            if (bus.cs_n) begin
               rd_index_d = idx_inc;
               if (idx_inc == count_q) begin
                  state_d = DONE;
                  done_d  = grant_q;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            grant_d = '0;
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         rd_index_q <= '0;
         count_q    <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         owner_q    <= '0;
         last_q     <= OW'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         rd_index_q <= rd_index_d;
         count_q    <= count_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.rd_index = rd_index_q;
   assign bus.grant    = grant_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - scoreboard bench for spi_tx_arbiter with two requesters
module tb_spi_tx_arbiter;
   localparam int NUM_REQ = 2;
   localparam int IDX_W   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dif ();

   spi_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int tv_cnt   = 0;
   int tv_bad   = 0;

   logic [31:0] exp_word_q[$];
   logic [31:0] exp_done_q[$];

   function automatic logic [31:0] word(input int r, input int i);
      return ((r == 0) ? 32'h0000_00A0 : 32'h0000_00B0) + 32'(i);
   endfunction

   assign dif.rd_data = {word(1, int'(dif.rd_index)), word(0, int'(dif.rd_index))};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (dif.tx_valid) tv_cnt++;
         if (dif.tx_valid && dif.grant == '0) tv_bad++;
         if (dif.done != '0) begin
            if (exp_done_q.size() == 0) check_eq("done_unexpected", 32'(dif.done), 32'h0);
            else check_eq("done_owner", 32'(dif.done), exp_done_q.pop_front());
         end
      end
   end

   task automatic wait_grant(input logic [1:0] exp);
      for (int i = 0; i < 50; i++) begin
         if (dif.grant != '0) break;
         @(negedge clk);
      end
      check_eq("grant", 32'(dif.grant), 32'(exp));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (dif.grant == '0) break;
         @(negedge clk);
      end
      check_eq("grant_idle", 32'(dif.grant), 32'h0);
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dif.tx_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("valid_timeout", 32'h0, 32'h1);
   endtask

   task automatic push_burst(input int r, input int n);
      for (int i = 0; i < n; i++) exp_word_q.push_back(word(r, i));
      exp_done_q.push_back(32'(1 << r));
   endtask

   task automatic do_frame(input bit simul);
      logic [31:0] exp;
      bit ok;
      exp = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 32'hDEAD_BEEF;
      dif.cs_n = 1'b0;
      wait_valid(ok);
      if (ok) begin
         check_eq("tx_data", dif.tx_data, exp);
         dif.tx_ready = 1'b1;
         if (simul) dif.cs_n = 1'b1;
         @(negedge clk);
         dif.tx_ready = 1'b0;
         check_eq("valid_drop", 32'(dif.tx_valid), 32'h0);
      end
      dif.cs_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_tx_data"},  dif.tx_data, 32'h0);
      check_eq({tag, "_tx_valid"}, 32'(dif.tx_valid), 32'h0);
      check_eq({tag, "_rd_index"}, 32'(dif.rd_index), 32'h0);
      check_eq({tag, "_grant"},    32'(dif.grant), 32'h0);
      check_eq({tag, "_done"},     32'(dif.done), 32'h0);
      check_eq({tag, "_busy"},     32'(dif.busy), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      exp_word_q.delete();
      exp_done_q.delete();
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int tv_snap;
      logic [1:0] order[4];
      dif.cs_n     = 1'b1;
      dif.tx_ready = 1'b0;
      dif.req      = '0;
      dif.len      = '0;
      @(negedge clk);
      do_reset();

      // single burst; len change after grant must be ignored
      dif.len = {16'd0, 16'd3};
      dif.req = 2'b01;
      wait_grant(2'b01);
      push_burst(0, 3);
      dif.req = 2'b00;
      dif.len = {16'd0, 16'd7};
      for (int f = 0; f < 3; f++) do_frame(1'b0);
      wait_idle();
      check_eq("single_done_seen", 32'(exp_done_q.size()), 32'h0);

      // contention from reset, both held: 0,1,0,1
      do_reset();
      dif.len = {16'd2, 16'd2};
      dif.req = 2'b11;
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
      for (int b = 0; b < 4; b++) begin
         wait_grant(order[b]);
         push_burst((order[b] == 2'b01) ? 0 : 1, 2);
         if (b == 3) dif.req = 2'b00;
         for (int f = 0; f < 2; f++) do_frame(1'b0);
         wait_idle();
      end
      check_eq("rr_done_seen", 32'(exp_done_q.size()), 32'h0);

      // abort then simultaneous ready + cs_n rise
      dif.len = {16'd0, 16'd2};
      dif.req = 2'b01;
      wait_grant(2'b01);
      push_burst(0, 2);
      dif.req = 2'b00;
      dif.cs_n = 1'b0;
      wait_valid(ok);
      check_eq("abort_tx_data", dif.tx_data, exp_word_q[0]);
      dif.cs_n = 1'b1;
      @(negedge clk);
      check_eq("abort_valid", 32'(dif.tx_valid), 32'h0);
      check_eq("abort_rd_index", 32'(dif.rd_index), 32'h0);
      @(negedge clk);
      do_frame(1'b1);
      do_frame(1'b0);
      wait_idle();
      check_eq("abort_done_seen", 32'(exp_done_q.size()), 32'h0);

      // reset mid-burst on requester 1, then re-arbitration from requester 0
      dif.len = {16'd3, 16'd0};
      dif.req = 2'b10;
      wait_grant(2'b10);
      push_burst(1, 3);
      dif.req = 2'b00;
      do_frame(1'b0);
      do_reset();
      dif.len = {16'd1, 16'd1};
      dif.req = 2'b11;
      wait_grant(2'b01);
      push_burst(0, 1);
      dif.req = 2'b00;
      do_frame(1'b0);
      wait_idle();
      check_eq("post_rst_done_seen", 32'(exp_done_q.size()), 32'h0);

      // zero length
      tv_snap = tv_cnt;
      dif.len = {16'd0, 16'd0};
      dif.req = 2'b10;
      exp_done_q.push_back(32'h2);
      wait_grant(2'b10);
      check_eq("zl_done", 32'(dif.done), 32'h2);
      dif.req = 2'b00;
      @(negedge clk);
      check_eq("zl_grant_one_cycle", 32'(dif.grant), 32'h0);
      check_eq("zl_done_one_cycle", 32'(dif.done), 32'h0);
      repeat (3) @(negedge clk);
      check_eq("zl_no_valid", 32'(tv_cnt - tv_snap), 32'h0);
      check_eq("zl_busy", 32'(dif.busy), 32'h0);

      check_eq("valid_without_grant", 32'(tv_bad), 32'h0);
      check_eq("word_queue_empty", 32'(exp_word_q.size()), 32'h0);
      check_eq("done_queue_empty", 32'(exp_done_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
